// File: rtl/cordic_rotate_seq.sv
// cordic_rotate_seq
//   Iterative rotation-mode CORDIC. Rotates a signed 16-bit vector (in_x, in_y)
//   counter-clockwise by a binary angle (0x4000 = +90 degrees, wraps mod 2^16).
//   One micro-rotation is performed per clock. The CORDIC gain is compensated
//   with a shift-add constant, and the result is saturated to 16 bits.
//   Only one transaction is in flight at a time.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is high only in IDLE)
//   in_x, in_y            signed input vector
//   in_angle              rotation angle in binary angle units
//   out_valid / out_ready output handshake (out_valid is high only in OUT)
//   out_x, out_y          rotated vector, gain-compensated and saturated
module cordic_rotate_seq #(
    parameter int ITERS = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_x,
    input  logic signed [15:0] in_y,
    input  logic        [15:0] in_angle,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_x,
    output logic signed [15:0] out_y
);

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        OUT
    } state_t;

    localparam logic [3:0] LAST = 4'(ITERS - 1);

    state_t             state;
    state_t             state_next;
    logic signed [17:0] x;
    logic signed [17:0] y;
    logic signed [15:0] z;
    logic        [3:0]  iter;

    // atan(2^-k) expressed in binary angle units.
    function automatic logic signed [15:0] atan_lut(input logic [3:0] k);
        case (k)
            4'd0:    return 16'sd8192;
            4'd1:    return 16'sd4836;
            4'd2:    return 16'sd2555;
            4'd3:    return 16'sd1297;
            4'd4:    return 16'sd651;
            4'd5:    return 16'sd326;
            4'd6:    return 16'sd163;
            4'd7:    return 16'sd81;
            4'd8:    return 16'sd41;
            4'd9:    return 16'sd20;
            4'd10:   return 16'sd10;
            4'd11:   return 16'sd5;
            default: return 16'sd0;
        endcase
    endfunction

    // Approximates 1/K = 0.6074 with 1/2 + 1/8 - 1/64 - 1/512. The products
    // stay well inside 18 bits, since |v| never exceeds about 76,300.
    function automatic logic signed [17:0] gain_comp(input logic signed [17:0] v);
        return (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

    // Pre-rotation by 180 degrees. It moves angles in quadrants 1 and 2 into
    // the range that CORDIC converges over, which is [-90, +90) degrees.
    logic               pre_flip;
    logic signed [17:0] ext_x;
    logic signed [17:0] ext_y;
    assign pre_flip = in_angle[15] ^ in_angle[14];
    assign ext_x    = 18'(in_x);
    assign ext_y    = 18'(in_y);

    // Micro-rotation datapath.
    logic               dir_pos;
    logic               last_iter;
    logic signed [17:0] x_sh;
    logic signed [17:0] y_sh;
    logic signed [17:0] x_rot;
    logic signed [17:0] y_rot;
    logic signed [15:0] z_rot;

    assign dir_pos   = ~z[15];
    assign last_iter = (iter == LAST);

    // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        x_sh  = x >>> iter;
        y_sh  = y >>> iter;
        x_rot = x;
        y_rot = y;
        z_rot = z;
        if (dir_pos) begin
            x_rot = x - y_sh;
            y_rot = y + x_sh;
            z_rot = z - atan_lut(iter);
        end else begin
            x_rot = x + y_sh;
            y_rot = y - x_sh;
            z_rot = z + atan_lut(iter);
        end
    end

    // NOTE: sequential state is only ever written with non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid) state_next = ROT;
            ROT:     if (last_iter) state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            z     <= '0;
            iter  <= '0;
            out_x <= '0;
            out_y <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                x    <= pre_flip ? -ext_x : ext_x;
                y    <= pre_flip ? -ext_y : ext_y;
                z    <= pre_flip ? (in_angle ^ 16'h8000) : in_angle;
                iter <= '0;
            end
        end else if (state == ROT) begin
            x    <= x_rot;
            y    <= y_rot;
            z    <= z_rot;
            iter <= iter + 4'd1;
            if (last_iter) begin
                out_x <= sat16(gain_comp(x_rot));
                out_y <= sat16(gain_comp(y_rot));
            end
        end
    end

endmodule

// File: doc/cordic_rotate_seq.md
# cordic_rotate_seq

Iterative rotation-mode CORDIC: rotates a signed 16-bit 2D vector by a binary angle, one micro-rotation per clock, with built-in gain compensation. It is the inverse direction of the combinational vectoring unit: that unit takes a vector to a magnitude, and this block takes a vector plus an angle back to Cartesian x/y. It serves the ray-marching pipeline for camera/ray-direction rotation and light-vector placement. Valid/ready handshakes on both sides; one transaction in flight.

## Interface
- ITERS, 12, number of micro-rotations, legal 1..12
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block can accept input
- in_x  in  16  signed input x
- in_y  in  16  signed input y
- in_angle  in  16  rotation angle, binary angle units (0x4000 = +90°, 0x8000 = 180°, wraps mod 2^16), counter-clockwise positive
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_x  out  16  signed rotated x, gain-compensated, saturated
- out_y  out  16  signed rotated y, gain-compensated, saturated

## Operation
- FSM states: IDLE, ROT, OUT. `in_ready` = (state==IDLE). `out_valid` = (state==OUT).
- IDLE: on in_valid && in_ready, load the working registers and go to ROT, with iteration counter i=0.
  - Working registers: x, y are 18-bit signed, sign-extended from the input; z is 16-bit.
- Pre-rotation on load: if in_angle[15:14] is 01 or 10, then x=-in_x, y=-in_y, z=in_angle^16'h8000. Otherwise pass through. Residual z always lies in [-0x4000, 0x3FFF].
- ROT, one micro-rotation per clock, d = (z >= 0):
  - d=1: x' = x-(y>>>i), y' = y+(x>>>i), z' = z-A[i]
  - d=0: x' = x+(y>>>i), y' = y-(x>>>i), z' = z+A[i]
  - `>>>` is arithmetic (floor).
  - A[0..11] = 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5.
- On the edge performing iteration i=ITERS-1:
  - compute g(v) = (v>>>1)+(v>>>3)-(v>>>6)-(v>>>9) (≈0.6074) on the post-iteration x and y, at 18-bit width;
  - saturate to [-32768, 32767];
  - register into out_x/out_y; go to OUT.
- OUT: out_x/out_y are held stable. On out_ready, go to IDLE. in_valid is ignored in ROT and OUT.
- Gain × compensation = 1.0003. The 18-bit working width never overflows for any 16-bit input (max |v| ≈ 76,300).
- Reset (any state, asynchronous): state=IDLE, i=0, x=y=0, z=0, out_x=out_y=0, out_valid=0, in_ready=1 one the reset is released. A transaction in progress is discarded; no partial output.

## Timing
- Accept edge E, then out_valid rises after edge E+ITERS (ITERS clocks of ROT). Result is visible from cycle E+ITERS.
- Output handshake completes on the edge where out_valid && out_ready. in_ready rises in the following cycle.
- Minimum interval between accepts: ITERS+2 cycles (ITERS+2 = 14 at the default).
- Output stalls indefinitely while out_ready=0; values and out_valid hold.
- out_ready high before out_valid has no effect. out_ready asserted in the same cycle out_valid rises completes the transfer on the next edge.

## Test plan
- Reset: assert rst_n=0 mid-ROT with any input → outputs go to 0 immediately, out_valid=0, in_ready=1 after release, and no result is ever produced for the aborted input.
- (10000,0), angle 0x4000 → out (0±6, 10000±6); angle 0x2000 → (7071±6, 7071±6); out_valid is seen exactly 12 cycles after the accept edge.
- Quadrant/wrap: (10000,0), angles 0x8000 → (-10000±6, 0±6); 0xC000 → (0±6, -10000±6); 0xE000 → (7071±6, -7071±6).
- Saturation: (32767,32767), angle 0x2000 → out_y=32767, out_x=0±6; (-32768,-32768), angle 0x2000 → out_y=-32768.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and a different input → out_x/out_y remain stable, in_ready=0, second input not accepted until one cycle after the handshake. The second result is then correct.
- Back-to-back: stream 20 random vectors/angles with random out_ready → every result is within ±8 LSB of the float reference (computed with saturation); order is preserved; no drops or duplicates.
